axi_slv_mem_responder: RTL and testbench

Synthesizable AXI4 slave with a byte-addressed internal memory. It sits at the slave end of the AXI link driven by the master VIP in the ex_sim block design, and lets the master VIP stimulus run against real RTL instead of a slave VIP. Write and read channels are handled by independent state machines. Responses are OKAY or SLVERR.

---
 rtl/axi_slv_mem_responder.sv | 256 +++++++++++++++++++++++++
 tb/tb_axi_slv_mem_responder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slv_mem_responder.sv
// AXI4 slave backed by a byte-addressed internal memory.
// The write and read channels use independent FSMs and share only the storage array.
module axi_slv_mem_responder #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MEM_AW = 12
) (
    input  logic                clock,
    input  logic                reset,

    input  logic [ID_W-1:0]     s_axi_awid,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,

    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,

    output logic [ID_W-1:0]     s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,

    input  logic [ID_W-1:0]     s_axi_arid,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,

    output logic [ID_W-1:0]     s_axi_rid,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = MEM_AW - OFF_W;
    localparam int WORDS = 1 << IDX_W;

    localparam logic [2:0] SIZE_MAX    = 3'(OFF_W);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    logic [DATA_W-1:0] mem [WORDS];

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        return addr[MEM_AW-1:OFF_W];
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(
        input logic [ADDR_W-1:0] addr,
        input logic [7:0]        len,
        input logic [2:0]        size,
        input logic [1:0]        burst
    );
        logic [ADDR_W-1:0] step;
        logic [ADDR_W-1:0] bound;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] nxt;
        step  = ADDR_W'(1) << size;
        bound = (ADDR_W'(len) + ADDR_W'(1)) << size;
        base  = addr & ~(bound - ADDR_W'(1));
        case (burst)
            BURST_FIXED: nxt = addr;
            BURST_INCR:  nxt = (addr & ~(step - ADDR_W'(1))) + step;
            // Wrap stays inside the (len+1)*step window containing the start address.
            BURST_WRAP:  nxt = base | ((addr + step) & (bound - ADDR_W'(1)));
            default:     nxt = addr;
        endcase
        return nxt;
    endfunction

    function automatic logic cfg_error(
        input logic [ADDR_W-1:0] addr,
        input logic [7:0]        len,
        input logic [2:0]        size,
        input logic [1:0]        burst
    );
        logic [ADDR_W-1:0] step;
        logic              wrap;
        step = ADDR_W'(1) << size;
        wrap = (burst == BURST_WRAP);
        return (burst == 2'b11) || (size > SIZE_MAX)
            || (wrap && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}))
            || (wrap && ((addr & (step - ADDR_W'(1))) != '0));
    endfunction

    // ---------------------------------------------------------------- write
    w_state_t          w_state, w_next;
    logic [ID_W-1:0]   w_id;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_len;
    logic [2:0]        w_size;
    logic [1:0]        w_burst;
    logic [7:0]        w_cnt;
    logic              w_cfg_err;
    logic              w_last_err;

    logic aw_hs, w_hs, b_hs, w_final;
    assign aw_hs   = s_axi_awvalid && s_axi_awready;
    assign w_hs    = s_axi_wvalid && s_axi_wready;
    assign b_hs    = s_axi_bvalid && s_axi_bready;
    assign w_final = (w_cnt == w_len);

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_final) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // NOTE: state and outputs use <= so every flop samples pre-edge values; = here would race with other blocks.
    always_ff @(posedge clock) begin
        if (reset) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            s_axi_bid     <= '0;
            w_id          <= '0;
            w_addr        <= '0;
            w_len         <= '0;
            w_size        <= '0;
            w_burst       <= '0;
            w_cnt         <= '0;
            w_cfg_err     <= 1'b0;
            w_last_err    <= 1'b0;
        end else begin
            w_state       <= w_next;
            // Ready/valid are registered copies of the next-state decode.
            s_axi_awready <= (w_next == W_IDLE);
            s_axi_wready  <= (w_next == W_DATA);
            s_axi_bvalid  <= (w_next == W_RESP);
            if (aw_hs) begin
                w_id       <= s_axi_awid;
                w_addr     <= s_axi_awaddr;
                w_len      <= s_axi_awlen;
                w_size     <= s_axi_awsize;
                w_burst    <= s_axi_awburst;
                w_cnt      <= '0;
                w_cfg_err  <= cfg_error(s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst);
                w_last_err <= 1'b0;
            end
            if (w_hs) begin
                w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
                w_cnt  <= w_cnt + 8'd1;
                if (s_axi_wlast != w_final) w_last_err <= 1'b1;
                if (w_final) begin
                    s_axi_bid   <= w_id;
                    s_axi_bresp <= (w_cfg_err || w_last_err || (s_axi_wlast != w_final))
                                   ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

    // NOTE: the storage array has no reset; contents survive reset and need no clear logic.
    always_ff @(posedge clock) begin
        if (!reset && w_hs && !w_cfg_err) begin
            for (int b = 0; b < BYTES; b++) begin
                if (s_axi_wstrb[b]) mem[word_idx(w_addr)][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

    // ----------------------------------------------------------------- read
    r_state_t          r_state, r_next;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic [7:0]        r_cnt;
    logic              r_err;

    logic ar_hs, r_hs, r_final;
    assign ar_hs   = s_axi_arvalid && s_axi_arready;
    assign r_hs    = s_axi_rvalid && s_axi_rready;
    assign r_final = (r_cnt == r_len);

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_FETCH;
            R_FETCH: r_next = R_DATA;
            R_DATA:  if (r_hs) r_next = r_final ? R_IDLE : R_FETCH;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rid     <= '0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
            s_axi_rlast   <= 1'b0;
            r_id          <= '0;
            r_addr        <= '0;
            r_len         <= '0;
            r_size        <= '0;
            r_burst       <= '0;
            r_cnt         <= '0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= r_next;
            s_axi_arready <= (r_next == R_IDLE);
            s_axi_rvalid  <= (r_next == R_DATA);
            if (ar_hs) begin
                r_id    <= s_axi_arid;
                r_addr  <= s_axi_araddr;
                r_len   <= s_axi_arlen;
                r_size  <= s_axi_arsize;
                r_burst <= s_axi_arburst;
                r_cnt   <= '0;
                r_err   <= cfg_error(s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst);
            end
            // Sampling the array here sees pre-edge contents, so a same-cycle write reads old data.
            if (r_state == R_FETCH) begin
                s_axi_rid   <= r_id;
                s_axi_rdata <= r_err ? '0 : mem[word_idx(r_addr)];
                s_axi_rresp <= r_err ? RESP_SLVERR : RESP_OKAY;
                s_axi_rlast <= r_final;
            end
            if (r_hs) begin
                r_addr <= next_addr(r_addr, r_len, r_size, r_burst);
                r_cnt  <= r_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_axi_slv_mem_responder.sv
// Directed bench for axi_slv_mem_responder: B and R beats are checked against scoreboard queues.
module tb_axi_slv_mem_responder;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MEM_AW = 12;
    localparam int BOUND  = 200;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] WRAP   = 2'b10;

    localparam int WAIT_AW = 0, WAIT_W = 1, WAIT_B = 2, WAIT_AR = 3, WAIT_R = 4;

    logic                clock = 1'b0;
    logic                reset;
    logic [ID_W-1:0]     awid, bid, arid, rid;
    logic [ADDR_W-1:0]   awaddr, araddr;
    logic [7:0]          awlen, arlen;
    logic [2:0]          awsize, arsize;
    logic [1:0]          awburst, arburst, bresp, rresp;
    logic                awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic                arvalid, arready, rlast, rvalid, rready;
    logic [DATA_W-1:0]   wdata, rdata;
    logic [DATA_W/8-1:0] wstrb;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } b_exp_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } r_exp_t;

    b_exp_t            b_q[$];
    r_exp_t            r_q[$];
    logic [DATA_W-1:0] wr_data[$];
    logic [DATA_W-1:0] rd_data[$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    axi_slv_mem_responder #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW)
    ) dut (
        .clock(clock), .reset(reset),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awsize(awsize), .s_axi_awburst(awburst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            WAIT_AW: return awready;
            WAIT_W:  return wready;
            WAIT_B:  return bvalid;
            WAIT_AR: return arready;
            default: return rvalid;
        endcase
    endfunction

    // All tasks start and end one time unit after a rising edge.
    task automatic wait_for(input int which, input string tag);
        int cnt = 0;
        while (!sig(which) && cnt < BOUND) begin
            @(posedge clock); #1;
            cnt++;
        end
        if (cnt >= BOUND) check({tag, " timeout"}, 64'd0, 64'd1);
    endtask

    task automatic write_burst(
        input logic [ID_W-1:0]     id,
        input logic [ADDR_W-1:0]   addr,
        input logic [7:0]          len,
        input logic [2:0]          size,
        input logic [1:0]          burst,
        input logic [DATA_W/8-1:0] strb,
        input int                  last_beat,
        input logic [1:0]          exp_resp,
        input string               tag
    );
        b_exp_t e;
        b_q.push_back('{id: id, resp: exp_resp});
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        wait_for(WAIT_AW, {tag, " aw"});
        @(posedge clock); #1;
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wr_data.pop_front(); wstrb = strb; wlast = (i == last_beat); wvalid = 1'b1;
            wait_for(WAIT_W, {tag, " w"});
            @(posedge clock); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        wait_for(WAIT_B, {tag, " b"});
        e = b_q.pop_front();
        check({tag, " bid"}, 64'(bid), 64'(e.id));
        check({tag, " bresp"}, 64'(bresp), 64'(e.resp));
        bready = 1'b1;
        @(posedge clock); #1;
        bready = 1'b0;
    endtask

    task automatic read_burst(
        input logic [ID_W-1:0]   id,
        input logic [ADDR_W-1:0] addr,
        input logic [7:0]        len,
        input logic [2:0]        size,
        input logic [1:0]        burst,
        input logic [1:0]        exp_resp,
        input int                hold_beat,
        input string             tag
    );
        r_exp_t e;
        for (int i = 0; i <= int'(len); i++)
            r_q.push_back('{id: id, data: rd_data.pop_front(), resp: exp_resp, last: (i == int'(len))});
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        wait_for(WAIT_AR, {tag, " ar"});
        @(posedge clock); #1;
        arvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wait_for(WAIT_R, {tag, " r"});
            e = r_q.pop_front();
            check($sformatf("%s beat%0d rdata", tag, i), 64'(rdata), 64'(e.data));
            check($sformatf("%s beat%0d rresp", tag, i), 64'(rresp), 64'(e.resp));
            check($sformatf("%s beat%0d rlast", tag, i), 64'(rlast), 64'(e.last));
            check($sformatf("%s beat%0d rid", tag, i), 64'(rid), 64'(e.id));
            if (i == hold_beat) begin
                repeat (3) begin
                    @(posedge clock); #1;
                    check($sformatf("%s hold rvalid", tag), 64'(rvalid), 64'd1);
                    check($sformatf("%s hold rdata", tag), 64'(rdata), 64'(e.data));
                end
            end
            rready = 1'b1;
            @(posedge clock); #1;
            rready = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst awready", 64'(awready), 64'd0);
        check("rst arready", 64'(arready), 64'd0);
        check("rst bvalid", 64'(bvalid), 64'd0);
        check("rst rvalid", 64'(rvalid), 64'd0);
        check("rst rdata", 64'(rdata), 64'd0);
        check("rst bresp", 64'(bresp), 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        check("post-rst awready", 64'(awready), 64'd1);
        check("post-rst arready", 64'(arready), 64'd1);

        // 1: single beat
        wr_data.push_back(32'hDEAD_BEEF);
        write_burst(4'h5, 32'h10, 8'd0, 3'd2, INCR, 4'hF, 0, OKAY, "t1 wr");
        rd_data.push_back(32'hDEAD_BEEF);
        read_burst(4'h3, 32'h10, 8'd0, 3'd2, INCR, OKAY, -1, "t1 rd");

        // 2: INCR burst with back-pressure on the second beat
        for (int i = 1; i <= 4; i++) wr_data.push_back(32'(i));
        write_burst(4'h1, 32'h100, 8'd3, 3'd2, INCR, 4'hF, 3, OKAY, "t2 wr");
        for (int i = 1; i <= 4; i++) rd_data.push_back(32'(i));
        read_burst(4'h2, 32'h100, 8'd3, 3'd2, INCR, OKAY, 1, "t2 rd");

        // 3: WRAP ordering and illegal WRAP length
        for (int i = 0; i < 4; i++) wr_data.push_back(32'hA + 32'(i));
        write_burst(4'h4, 32'h200, 8'd3, 3'd2, INCR, 4'hF, 3, OKAY, "t3 wr");
        rd_data.push_back(32'hC); rd_data.push_back(32'hD);
        rd_data.push_back(32'hA); rd_data.push_back(32'hB);
        read_burst(4'h6, 32'h208, 8'd3, 3'd2, WRAP, OKAY, -1, "t3 wrap");
        for (int i = 0; i < 3; i++) rd_data.push_back(32'h0);
        read_burst(4'h7, 32'h200, 8'd2, 3'd2, WRAP, SLVERR, -1, "t3 wrap len2");

        // 4: strobes and an early wlast
        wr_data.push_back(32'h1122_3344);
        write_burst(4'h8, 32'h40, 8'd0, 3'd2, INCR, 4'hF, 0, OKAY, "t4 wr full");
        wr_data.push_back(32'hAABB_CCDD);
        write_burst(4'h8, 32'h40, 8'd0, 3'd2, INCR, 4'h5, 0, OKAY, "t4 wr strb");
        rd_data.push_back(32'h11BB_33DD);
        read_burst(4'h9, 32'h40, 8'd0, 3'd2, INCR, OKAY, -1, "t4 rd strb");
        wr_data.push_back(32'h55); wr_data.push_back(32'h66);
        write_burst(4'hA, 32'h80, 8'd1, 3'd2, INCR, 4'hF, 0, SLVERR, "t4 early wlast");
        rd_data.push_back(32'h55); rd_data.push_back(32'h66);
        read_burst(4'hA, 32'h80, 8'd1, 3'd2, INCR, OKAY, -1, "t4 rd wlast");

        // 5: reserved burst type and oversize beats
        wr_data.push_back(32'hFFFF_FFFF);
        write_burst(4'hB, 32'h40, 8'd0, 3'd2, 2'b11, 4'hF, 0, SLVERR, "t5 bad burst");
        rd_data.push_back(32'h11BB_33DD);
        read_burst(4'hB, 32'h40, 8'd0, 3'd2, INCR, OKAY, -1, "t5 rd unchanged");
        rd_data.push_back(32'h0);
        read_burst(4'hC, 32'h40, 8'd0, 3'd3, INCR, SLVERR, -1, "t5 bad size");

        // 6: concurrent 16-beat bursts, then reset in the middle of a read
        for (int i = 0; i < 16; i++) wr_data.push_back(32'h6000_0000 + 32'(i));
        write_burst(4'hD, 32'h600, 8'd15, 3'd2, INCR, 4'hF, 15, OKAY, "t6 prefill");
        for (int i = 0; i < 16; i++) wr_data.push_back(32'h4000_0000 + 32'(i));
        for (int i = 0; i < 16; i++) rd_data.push_back(32'h6000_0000 + 32'(i));
        fork
            write_burst(4'hE, 32'h400, 8'd15, 3'd2, INCR, 4'hF, 15, OKAY, "t6 conc wr");
            read_burst(4'hF, 32'h600, 8'd15, 3'd2, INCR, OKAY, -1, "t6 conc rd");
        join

        arid = 4'h2; araddr = 32'h400; arlen = 8'd15; arsize = 3'd2; arburst = INCR; arvalid = 1'b1;
        wait_for(WAIT_AR, "t6 rst ar");
        @(posedge clock); #1;
        arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_for(WAIT_R, "t6 rst r");
            check($sformatf("t6 rst beat%0d rdata", i), 64'(rdata), 64'(32'h4000_0000 + 32'(i)));
            rready = 1'b1;
            @(posedge clock); #1;
            rready = 1'b0;
        end
        wait_for(WAIT_R, "t6 rst r5");
        check("t6 beat5 rdata", 64'(rdata), 64'h4000_0004);
        reset = 1'b1;
        @(posedge clock); #1;
        check("t6 rst rvalid", 64'(rvalid), 64'd0);
        check("t6 rst arready", 64'(arready), 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        check("t6 rel arready", 64'(arready), 64'd1);
        check("t6 rel rvalid", 64'(rvalid), 64'd0);
        rd_data.push_back(32'h4000_0000);
        read_burst(4'h1, 32'h400, 8'd0, 3'd2, INCR, OKAY, -1, "t6 mem kept");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
